// File: rtl/systolic_array_sequencer_pkg.sv
// Shared types for the systolic array sequencer: controller states and the per-step result token.
package systolic_array_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRun,
        StDrain,
        StFlush
    } seq_state_e;

    typedef struct packed {
        logic valid;
        logic last;
    } seq_token_t;

endpackage

// File: rtl/seq_result_fifo.sv
// Result FIFO for the sequencer: registered storage, head always visible on o_data.
module seq_result_fifo #(
    parameter int unsigned Width = 129,
    parameter int unsigned Depth = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [Width-1:0]           i_data,
    input  logic                       i_pop,
    output logic [Width-1:0]           o_data,
    output logic [$clog2(Depth+1)-1:0] o_count,
    output logic                       o_empty
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = $clog2(Depth + 1);

    logic [Width-1:0] r_mem [Depth];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;

    assign w_full  = (r_count == CW'(Depth));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Upstream credit accounting must make this impossible.
    assert property (@(posedge clk) disable iff (!reset) !(i_push && w_full));

endmodule

// File: rtl/systolic_array_sequencer.sv
// Drives one systolic array through weight load, credit-gated batch streaming and drain.
// Every issued vector reserves a FIFO slot up front, so the array never has to stall.
module systolic_array_sequencer
    import systolic_array_sequencer_pkg::*;
#(
    parameter int unsigned DW        = 32,
    parameter int unsigned N         = 4,
    parameter int unsigned LAT       = 4,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned BW        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [N*N*DW-1:0]   cfg_weights,
    input  logic [BW-1:0]       cfg_batch,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DW-1:0]     in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*DW-1:0]     out_data,
    output logic                out_last,
    output logic                busy,
    output logic                arr_load_weights,
    output logic                arr_start,
    output logic [N*DW-1:0]     arr_x_in,
    output logic [N*N*DW-1:0]   arr_w_in,
    input  logic [N*DW-1:0]     arr_y_out,
    input  logic                arr_done
);
    localparam int unsigned VW  = N * DW;
    localparam int unsigned FW  = VW + 1;
    localparam int unsigned CW  = $clog2(OUT_DEPTH + 1);
    localparam int unsigned DCW = (LAT > 1) ? $clog2(LAT) : 1;

    seq_state_e        r_state;
    seq_state_e        w_state_next;
    logic [N*N*DW-1:0] r_weights;
    logic [BW-1:0]     r_remaining;
    logic [DCW-1:0]    r_drain_cnt;
    logic [CW-1:0]     r_inflight;
    seq_token_t        r_tok [LAT];
    seq_token_t        w_new_tok;
    logic              w_fire;
    logic              w_cfg_fire;
    logic              w_push;
    logic              w_pop;
    logic              w_credit_ok;
    logic              w_fifo_empty;
    logic [CW-1:0]     w_fifo_count;
    logic [FW-1:0]     w_fifo_head;

    assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_inflight}) < (CW + 1)'(OUT_DEPTH);
    assign w_cfg_fire  = cfg_valid && cfg_ready;
    assign w_push      = arr_done && r_tok[LAT-1].valid;
    assign w_pop       = out_valid && out_ready;
    assign busy        = (r_state != StIdle);
    assign out_valid   = !w_fifo_empty;
    assign out_data    = w_fifo_head[FW-1:1];
    assign out_last    = w_fifo_head[0];
    assign arr_w_in    = r_weights;

    always_comb begin
        w_state_next     = r_state;
        cfg_ready        = 1'b0;
        in_ready         = 1'b0;
        arr_load_weights = 1'b0;
        arr_start        = 1'b0;
        arr_x_in         = '0;
        w_new_tok        = '0;
        w_fire           = 1'b0;
        case (r_state)
            StIdle: begin
                cfg_ready = 1'b1;
                if (cfg_valid) w_state_next = StLoad;
            end
            StLoad: begin
                arr_load_weights = 1'b1;
                w_state_next     = (r_remaining != '0) ? StRun : StIdle;
            end
            StRun: begin
                in_ready = (r_remaining != '0) && w_credit_ok;
                w_fire   = in_valid && in_ready;
                if (w_fire) begin
                    arr_start       = 1'b1;
                    arr_x_in        = in_data;
                    w_new_tok.valid = 1'b1;
                    w_new_tok.last  = (r_remaining == BW'(1));
                end
                if ((r_remaining == '0) || (w_fire && (r_remaining == BW'(1)))) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                // Bubbles push the tail through; their results already hold credits.
                if (r_drain_cnt == DCW'(LAT - 1)) w_state_next = StFlush;
                else                              arr_start    = 1'b1;
            end
            StFlush: begin
                if (w_fifo_empty && (r_inflight == '0)) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_weights   <= '0;
            r_remaining <= '0;
            r_drain_cnt <= '0;
            r_inflight  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_cfg_fire) begin
                r_weights   <= cfg_weights;
                r_remaining <= cfg_batch;
            end else if (w_fire) begin
                r_remaining <= r_remaining - 1'b1;
            end
            if (r_state != StDrain) r_drain_cnt <= '0;
            else if (arr_start)     r_drain_cnt <= r_drain_cnt + 1'b1;
            if (w_fire && !w_push)      r_inflight <= r_inflight + 1'b1;
            else if (!w_fire && w_push) r_inflight <= r_inflight - 1'b1;
        end
    end

    // Token pipe mirrors the array pipeline; it only advances on array steps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(LAT); i++) r_tok[i] <= '0;
        end else if (arr_start) begin
            r_tok[0] <= w_new_tok;
            for (int i = 1; i < int'(LAT); i++) r_tok[i] <= r_tok[i-1];
        end
    end

    seq_result_fifo #(
        .Width (FW),
        .Depth (OUT_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({arr_y_out, r_tok[LAT-1].last}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Directed bench for systolic_array_sequencer with an array stub that echoes x_in after LAT steps.
module tb_systolic_array_sequencer;
    localparam int DW        = 32;
    localparam int N         = 4;
    localparam int LAT       = 4;
    localparam int OUT_DEPTH = 4;
    localparam int BW        = 8;
    localparam int VW        = N * DW;
    localparam int WW        = N * N * DW;

    logic          clk;
    logic          reset;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [WW-1:0] cfg_weights;
    logic [BW-1:0] cfg_batch;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          arr_load_weights;
    logic          arr_start;
    logic [VW-1:0] arr_x_in;
    logic [WW-1:0] arr_w_in;
    logic [VW-1:0] arr_y_out;
    logic          arr_done;

    int errors;
    int checks;

    logic [VW-1:0] tx_vec [16];
    int            tx_n;
    int            tx_idx;
    logic [VW-1:0] rx_data [16];
    logic          rx_last [16];
    int n_acc, n_start, n_bubble, n_load, n_rx, n_ov, n_gap;
    int cyc, first_hs, first_ov;

    systolic_array_sequencer #(
        .DW        (DW),
        .N         (N),
        .LAT       (LAT),
        .OUT_DEPTH (OUT_DEPTH),
        .BW        (BW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_weights      (cfg_weights),
        .cfg_batch        (cfg_batch),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .busy             (busy),
        .arr_load_weights (arr_load_weights),
        .arr_start        (arr_start),
        .arr_x_in         (arr_x_in),
        .arr_w_in         (arr_w_in),
        .arr_y_out        (arr_y_out),
        .arr_done         (arr_done)
    );

    // Array stub: x_in reappears on y_out after LAT start steps, done follows start by one cycle.
    logic [VW-1:0] stub_p [LAT];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) stub_p[i] <= '0;
            arr_done <= 1'b0;
        end else begin
            arr_done <= arr_start;
            if (arr_start) begin
                stub_p[0] <= arr_x_in;
                for (int i = 1; i < LAT; i++) stub_p[i] <= stub_p[i-1];
            end
        end
    end
    assign arr_y_out = stub_p[LAT-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [VW-1:0] mkvec(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [WW-1:0] mkw(input int seed);
        logic [WW-1:0] w;
        for (int i = 0; i < N * N; i++) w[i*DW +: DW] = 32'(seed + i);
        return w;
    endfunction

    task automatic clear_stats();
        n_acc = 0; n_start = 0; n_bubble = 0; n_load = 0; n_rx = 0; n_ov = 0; n_gap = 0;
        cyc = 0; first_hs = -1; first_ov = -1; tx_idx = 0; tx_n = 0;
    endtask

    // One clock: observe at the falling edge, return just after the rising edge.
    task automatic tick();
        logic hs;
        @(negedge clk);
        hs = in_valid && in_ready;
        if (hs) begin
            n_acc++;
            if (first_hs < 0) first_hs = cyc;
        end
        if (arr_start) n_start++;
        if (arr_start && !hs) n_bubble++;
        if (arr_start && !in_valid && (tx_idx < tx_n)) n_gap++;
        if (arr_load_weights) n_load++;
        if (out_valid) begin
            n_ov++;
            if (first_ov < 0) first_ov = cyc;
        end
        if (out_valid && out_ready && (n_rx < 16)) begin
            rx_data[n_rx] = out_data;
            rx_last[n_rx] = out_last;
            n_rx++;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (hs) tx_idx++;
    endtask

    task automatic start_batch(input int n, input logic [WW-1:0] w);
        int t;
        t = 0;
        while (!cfg_ready && t < 50) begin
            tick();
            t++;
        end
        if (!cfg_ready) begin
            errors++;
            checks++;
            $display("FAIL cfg_ready_wait: cfg_ready=%0b after %0d cycles, required 1", cfg_ready, t);
        end
        cfg_valid   = 1'b1;
        cfg_batch   = BW'(n);
        cfg_weights = w;
        tick();
        cfg_valid   = 1'b0;
        cfg_batch   = '0;
        cfg_weights = '0;
    endtask

    // Stream tx_vec with in_valid gated by mask bit c (bits past 31 read as 1) until idle or budget.
    task automatic run(input int budget, input logic [31:0] mask);
        for (int c = 0; c < budget; c++) begin
            in_valid = (tx_idx < tx_n) && ((c < 32) ? mask[c] : 1'b1);
            in_data  = (tx_idx < tx_n) ? tx_vec[tx_idx] : '0;
            tick();
            if (!busy) break;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cfg_ready !== 1'b1) begin errors++;
            $display("FAIL reset_cfg_ready: got %0b want 1", cfg_ready); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (arr_start !== 1'b0) begin errors++;
            $display("FAIL reset_arr_start: got %0b want 0", arr_start); end
        checks++; if (arr_load_weights !== 1'b0) begin errors++;
            $display("FAIL reset_load: got %0b want 0", arr_load_weights); end
        checks++; if ((in_ready !== 1'b0) || (arr_w_in !== '0) || (out_data !== '0)) begin
            errors++;
            $display("FAIL reset_data: in_ready=%0b w_in=%0h out_data=%0h want all 0",
                     in_ready, arr_w_in, out_data); end
        reset = 1'b1;
    endtask

    task automatic test_batch3();
        logic [WW-1:0] w;
        w = mkw(32'h1000);
        clear_stats();
        out_ready = 1'b1;
        tx_vec[0] = mkvec(1, 2, 3, 4);
        tx_vec[1] = mkvec(5, 6, 7, 8);
        tx_vec[2] = mkvec(9, 10, 11, 12);
        tx_n = 3;
        start_batch(3, w);
        checks++; if (arr_w_in !== w) begin errors++;
            $display("FAIL b3_w_in: got %0h want %0h", arr_w_in, w); end
        checks++; if (arr_load_weights !== 1'b1) begin errors++;
            $display("FAIL b3_load_now: got %0b want 1", arr_load_weights); end
        run(80, 32'hFFFF_FFFF);
        checks++; if (n_load !== 1) begin errors++;
            $display("FAIL b3_load_cycles: got %0d want 1", n_load); end
        checks++; if (n_rx !== 3) begin errors++;
            $display("FAIL b3_count: got %0d want 3", n_rx); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rx_data[i] !== tx_vec[i]) begin errors++;
                $display("FAIL b3_data[%0d]: got %0h want %0h", i, rx_data[i], tx_vec[i]); end
        end
        checks++; if ({rx_last[2], rx_last[1], rx_last[0]} !== 3'b100) begin errors++;
            $display("FAIL b3_last: got %b want 100", {rx_last[2], rx_last[1], rx_last[0]}); end
        checks++; if (n_bubble !== LAT - 1) begin errors++;
            $display("FAIL b3_bubbles: got %0d want %0d", n_bubble, LAT - 1); end
        checks++; if (n_start !== 3 + LAT - 1) begin errors++;
            $display("FAIL b3_starts: got %0d want %0d", n_start, 3 + LAT - 1); end
        checks++; if (first_ov - first_hs !== LAT + 1) begin errors++;
            $display("FAIL b3_latency: got %0d want %0d", first_ov - first_hs, LAT + 1); end
        checks++; if ((busy !== 1'b0) || (out_valid !== 1'b0)) begin errors++;
            $display("FAIL b3_idle: busy=%0b out_valid=%0b want 0 0", busy, out_valid); end
    endtask

    task automatic test_back_pressure();
        logic [7:0] lasts;
        clear_stats();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) tx_vec[k] = mkvec(16*k + 1, 16*k + 2, 16*k + 3, 16*k + 4);
        tx_n = 8;
        start_batch(8, mkw(32'h2000));
        run(20, 32'hFFFF_FFFF);
        checks++; if (n_acc !== OUT_DEPTH) begin errors++;
            $display("FAIL bp_accepted_stalled: got %0d want %0d", n_acc, OUT_DEPTH); end
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_in_ready_stalled: got %0b want 0", in_ready); end
        out_ready = 1'b1;
        run(200, 32'hFFFF_FFFF);
        checks++; if ((n_acc !== 8) || (n_rx !== 8)) begin errors++;
            $display("FAIL bp_count: accepted=%0d results=%0d want 8 8", n_acc, n_rx); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (rx_data[i] !== tx_vec[i]) begin errors++;
                $display("FAIL bp_data[%0d]: got %0h want %0h", i, rx_data[i], tx_vec[i]); end
            lasts[i] = rx_last[i];
        end
        checks++; if (lasts !== 8'h80) begin errors++;
            $display("FAIL bp_last: got %b want 10000000", lasts); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL bp_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_zero_batch();
        clear_stats();
        out_ready = 1'b1;
        start_batch(0, mkw(32'h3000));
        run(10, 32'hFFFF_FFFF);
        checks++; if (n_load !== 1) begin errors++;
            $display("FAIL zb_load: got %0d want 1", n_load); end
        checks++; if ((n_start !== 0) || (n_ov !== 0)) begin errors++;
            $display("FAIL zb_activity: starts=%0d out_valid_cycles=%0d want 0 0", n_start, n_ov);
        end
        checks++; if ((busy !== 1'b0) || (cfg_ready !== 1'b1)) begin errors++;
            $display("FAIL zb_idle: busy=%0b cfg_ready=%0b want 0 1", busy, cfg_ready); end
    endtask

    task automatic test_reset_mid_run();
        clear_stats();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tx_vec[k] = mkvec(100 + k, 200 + k, 300 + k, 400 + k);
        tx_n = 2;
        start_batch(5, mkw(32'h4000));
        run(8, 32'hFFFF_FFFF);
        checks++; if ((n_acc !== 2) || (busy !== 1'b1)) begin errors++;
            $display("FAIL rm_pre: accepted=%0d busy=%0b want 2 1", n_acc, busy); end
        reset = 1'b0;
        #1;
        checks++; if ((cfg_ready !== 1'b1) || (busy !== 1'b0) || (in_ready !== 1'b0)) begin
            errors++;
            $display("FAIL rm_ctrl: cfg_ready=%0b busy=%0b in_ready=%0b want 1 0 0",
                     cfg_ready, busy, in_ready); end
        checks++; if ((out_valid !== 1'b0) || (arr_start !== 1'b0) || (arr_load_weights !== 1'b0)
                      || (arr_w_in !== '0) || (out_last !== 1'b0)) begin
            errors++;
            $display("FAIL rm_outputs: out_valid=%0b start=%0b load=%0b w_in=%0h last=%0b want 0",
                     out_valid, arr_start, arr_load_weights, arr_w_in, out_last); end
        repeat (2) tick();
        reset = 1'b1;
        clear_stats();
        tx_vec[0] = mkvec(7, 77, 777, 7777);
        tx_n = 1;
        start_batch(1, mkw(32'h5000));
        run(60, 32'hFFFF_FFFF);
        checks++; if (n_rx !== 1) begin errors++;
            $display("FAIL rm_count: got %0d want 1", n_rx); end
        checks++; if ((rx_data[0] !== tx_vec[0]) || (rx_last[0] !== 1'b1)) begin errors++;
            $display("FAIL rm_result: data=%0h last=%0b want %0h 1",
                     rx_data[0], rx_last[0], tx_vec[0]); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL rm_idle: busy=%0b want 0", busy); end
    endtask

    task automatic test_bubbles();
        logic [3:0] lasts;
        clear_stats();
        out_ready = 1'b1;
        tx_vec[0] = mkvec(21, 22, 23, 24);
        tx_vec[1] = mkvec(31, 32, 33, 34);
        tx_vec[2] = mkvec(41, 42, 43, 44);
        tx_vec[3] = mkvec(51, 52, 53, 54);
        tx_n = 4;
        start_batch(4, mkw(32'h6000));
        // Cycle 0 is the load cycle; in_valid then runs 1,0,0,1,1...
        run(80, 32'hFFFF_FFF2);
        checks++; if (n_gap !== 0) begin errors++;
            $display("FAIL bub_idle_start: got %0d start cycles while idle, want 0", n_gap); end
        checks++; if (n_start !== 4 + LAT - 1) begin errors++;
            $display("FAIL bub_starts: got %0d want %0d", n_start, 4 + LAT - 1); end
        checks++; if (n_rx !== 4) begin errors++;
            $display("FAIL bub_count: got %0d want 4", n_rx); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rx_data[i] !== tx_vec[i]) begin errors++;
                $display("FAIL bub_data[%0d]: got %0h want %0h", i, rx_data[i], tx_vec[i]); end
            lasts[i] = rx_last[i];
        end
        checks++; if (lasts !== 4'b1000) begin errors++;
            $display("FAIL bub_last: got %b want 1000", lasts); end
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL bub_idle: busy=%0b want 0", busy); end
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        reset       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_weights = '0;
        cfg_batch   = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        clear_stats();
        test_reset();
        test_batch3();
        test_back_pressure();
        test_zero_batch();
        test_reset_mid_run();
        test_bubbles();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_array_sequencer.md
Name: systolic_array_sequencer

Overview:
Controller that sequences one parameterized systolic array instance through weight load, batched input streaming and pipeline drain. Upstream sees three valid/ready interfaces: a weight/config port, an input-vector stream and a result stream. Array steps are gated by credits so the result FIFO can never overflow, which keeps the array stall-free. The block sits between the softmax pipeline front-end and the array.

Parameters:
DW, 32, element width in bits
N, 4, array dimension (vector length, N*N weights)
LAT, 4, array steps from issuing a vector to its result appearing on arr_y_out (must be >= 1)
OUT_DEPTH, 4, result FIFO depth in entries (power of 2, >= 2)
BW, 8, batch-count width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset asserted)
cfg_valid  in  1  weight/config request
cfg_ready  out  1  high only in IDLE
cfg_weights  in  N*N*DW  weight matrix, packed row-major
cfg_batch  in  BW  number of input vectors in the batch
in_valid  in  1  input vector valid
in_ready  out  1  input vector accepted this cycle when in_valid&in_ready
in_data  in  N*DW  input vector
out_valid  out  1  result FIFO non-empty
out_ready  in  1  consumer ready
out_data  out  N*DW  result vector (FIFO head)
out_last  out  1  head entry is the final result of the batch
busy  out  1  state != IDLE
arr_load_weights  out  1  to array load_weights
arr_start  out  1  to array start; one array step per high cycle
arr_x_in  out  N*DW  to array x_in
arr_w_in  out  N*N*DW  to array w_in
arr_y_out  in  N*DW  from array y_out
arr_done  in  1  from array done; high the cycle after arr_start

Behaviour:
- Reset (reset=0, async): state=IDLE, every output 0 except cfg_ready=1. Weight register, counters, token pipe and FIFO are cleared. Reset mid-batch discards everything in flight.
- FSM IDLE -> LOAD -> RUN -> DRAIN -> FLUSH -> IDLE.
- IDLE: on cfg_valid&cfg_ready, latch cfg_weights into the weight register and cfg_batch into remaining. Go to LOAD.
- arr_w_in is always driven from the weight register.
- LOAD: exactly 1 cycle with arr_load_weights=1 and arr_start=0. Then go to RUN if batch>0, else to IDLE (no result emitted).
- RUN: in_ready = (remaining>0) && credit_ok, where credit_ok = (fifo_count + tokens_in_flight) < OUT_DEPTH.
  - On handshake: arr_start=1, arr_x_in=in_data, push token {valid=1, last=(remaining==1)}, decrement remaining.
  - Without a handshake: arr_start=0 and arr_x_in=0. The array does not advance.
  - When remaining reaches 0, go to DRAIN.
- DRAIN: issue exactly LAT-1 bubble steps (arr_start=1, arr_x_in=0, token valid=0). Bubbles ignore credits because all real results already hold reserved credits. Then go to FLUSH.
- Token pipe: LAT-stage shift register, shifted only on arr_start cycles. The token leaving the last stage is registered with arr_start. In the next cycle, if arr_done is high and the registered token is valid, push {arr_y_out, last} into the FIFO.
- FLUSH: wait until the FIFO is empty and the last entry has been popped, then go to IDLE.
- FIFO: pop on out_valid&out_ready. Simultaneous push and pop keeps the count unchanged. Push into a full FIFO cannot happen; this is asserted in simulation.
- out_data and out_last are the FIFO head (registered storage, no combinational path from arr_y_out).
- Latency: the first result is visible on out_valid LAT+1 cycles after its input handshake when there are no stalls.
- Counters saturate-free: remaining never underflows because it is only decremented when > 0.

Decomposition:
- Shared package: state enum (IDLE, LOAD, RUN, DRAIN, FLUSH) and token struct {valid, last}.
- One sub-module: seq_result_fifo (parameterized DW*N+1 wide, OUT_DEPTH deep, count output).

Test Plan:
Use an array stub that returns x_in delayed LAT steps, where only arr_start cycles count as steps.
- Reset: hold reset=0 for 3 cycles -> cfg_ready=1, busy=0, out_valid=0, arr_start=0, arr_load_weights=0.
- Batch of 3, out_ready=1 throughout, vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12}:
  - arr_load_weights is high for exactly 1 cycle.
  - 3 results arrive in order; out_last is set only on {9,...}.
  - DRAIN issues 3 bubbles; busy drops after the final pop.
- Back-pressure: batch=8 with out_ready=0:
  - exactly OUT_DEPTH (4) vectors are accepted, then in_ready=0;
  - raising out_ready resumes acceptance;
  - all 8 results arrive in order with no overflow assertion.
- cfg_batch=0 -> LOAD pulse, return to IDLE, no out_valid, no arr_start.
- Reset asserted mid-RUN after 2 of 5 vectors -> all outputs return to reset values at once; a following batch of 1 produces exactly one result, with out_last=1.
- Input bubbles (in_valid toggled 1,0,0,1) -> arr_start is low on the idle cycles and result order and values are preserved.
